// File: rtl/core_pkg.sv
// Shared core definitions: opcode encodings, instruction field positions and fetch FSM states.
package core_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_NDU    = 4'b0010;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LW     = 4'b1010;
  localparam logic [3:0] OP_BEQ    = 4'b1011;
  localparam logic [3:0] OP_JAL    = 4'b1101;
  localparam logic [3:0] OP_BUBBLE = 4'b1111;

  localparam int OPC_LSB   = 12;
  localparam int RA_LSB    = 9;
  localparam int RB_LSB    = 6;
  localparam int RC_LSB    = 3;
  localparam int FUNCT_LSB = 0;
  localparam int IMM6_W    = 6;
  localparam int IMM9_W    = 9;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_ir_unit_pc_next_calc.sv
// Combinational next-PC: JAL (PC+sext imm9) over taken BEQ (PC+sext imm6) over PC+1, all modulo 2^PC_W.
// Also exports the sign-extended imm6 so the top reuses the same extension.
module pc_next_calc
  import core_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] ir,
  input  logic               branch,
  input  logic               jal,
  input  logic               zero,
  output logic [PC_W-1:0]    imm6_sx,
  output logic [PC_W-1:0]    next_pc
);

  logic [PC_W-1:0] imm9_sx;

  assign imm6_sx = {{(PC_W-IMM6_W){ir[IMM6_W-1]}}, ir[IMM6_W-1:0]};
  assign imm9_sx = {{(PC_W-IMM9_W){ir[IMM9_W-1]}}, ir[IMM9_W-1:0]};

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (jal) begin
      next_pc = pc + imm9_sx;
    end else if (branch && zero) begin
      next_pc = pc + imm6_sx;
    end
  end

endmodule

// File: rtl/fetch_ir_unit.sv
// Fetch stage / PC owner: IMEM req/ack fetch into IR, field decode, PC update on pc_write.
// Optional ack-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_ir_unit
  import core_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter int              INSTR_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  output logic [3:0]         opcode,
  output logic [1:0]         funct,
  output logic [2:0]         ra,
  output logic [2:0]         rb,
  output logic [2:0]         rc,
  output logic [PC_W-1:0]    imm6_sx,
  input  logic               pc_write,
  input  logic               branch,
  input  logic               jal,
  input  logic               zero,
  output logic [PC_W-1:0]    cur_pc,
  output logic [PC_W-1:0]    link_pc,
  output logic               fetch_fault
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, next_pc;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               pend_q, pend_d, pend_br_q, pend_br_d;
  logic               pend_jal_q, pend_jal_d, pend_zero_q, pend_zero_d;
  logic               timeout_hit;

  // A pc_write seen during REQ is parked here and replayed on the ack edge.
  logic upd_req, upd_br, upd_jal, upd_zero;
  assign upd_req  = pend_q | pc_write;
  assign upd_br   = pend_q ? pend_br_q   : branch;
  assign upd_jal  = pend_q ? pend_jal_q  : jal;
  assign upd_zero = pend_q ? pend_zero_q : zero;

  pc_next_calc #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_pc_next (
    .pc      (pc_q),
    .ir      (ir_q),
    .branch  (upd_br),
    .jal     (upd_jal),
    .zero    (upd_zero),
    .imm6_sx (imm6_sx),
    .next_pc (next_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  assign timeout_hit = (state_q == REQ) && !imem_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q | timeout_hit;
    if (state_q == IDLE && fetch_start) begin
      cnt_d = '0;
    end else if (state_q == REQ && !imem_ack && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_br_q   <= 1'b0;
      pend_jal_q  <= 1'b0;
      pend_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      pend_q      <= pend_d;
      pend_br_q   <= pend_br_d;
      pend_jal_q  <= pend_jal_d;
      pend_zero_q <= pend_zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_start) state_d = REQ;
      REQ:     if (imem_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    pend_d      = pend_q;
    pend_br_d   = pend_br_q;
    pend_jal_d  = pend_jal_q;
    pend_zero_d = pend_zero_q;
    if (state_q == IDLE) begin
      if (pc_write) pc_d = next_pc;
      if (fetch_start) ir_valid_d = 1'b0;
    end else if (imem_ack || timeout_hit) begin
      ir_d       = imem_ack ? imem_rdata : INSTR_W'({OP_BUBBLE, 12'h000});
      ir_valid_d = 1'b1;
      pend_d     = 1'b0;
      if (upd_req) pc_d = next_pc;
    end else if (pc_write && !pend_q) begin
      pend_d      = 1'b1;
      pend_br_d   = branch;
      pend_jal_d  = jal;
      pend_zero_d = zero;
    end
  end

  always_comb begin
    imem_req  = (state_q == REQ);
    imem_addr = pc_q;
    ir_valid  = ir_valid_q;
    opcode    = ir_q[OPC_LSB +: 4];
    ra        = ir_q[RA_LSB +: 3];
    rb        = ir_q[RB_LSB +: 3];
    rc        = ir_q[RC_LSB +: 3];
    funct     = ir_q[FUNCT_LSB +: 2];
    cur_pc    = pc_q;
    link_pc   = pc_q + PC_W'(1);
  end

endmodule

// File: tb/tb_fetch_ir_unit.sv
// Directed bench for fetch_ir_unit: fetch handshake, field decode, PC update paths, reset, ack timeout.
module tb_fetch_ir_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_start = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        ir_valid;
  logic [3:0]  opcode;
  logic [1:0]  funct;
  logic [2:0]  ra, rb, rc;
  logic [15:0] imm6_sx;
  logic        pc_write = 1'b0, branch = 1'b0, jal = 1'b0, zero = 1'b0;
  logic [15:0] cur_pc, link_pc;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  fetch_ir_unit dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .opcode(opcode), .funct(funct), .ra(ra), .rb(rb), .rc(rc),
    .imm6_sx(imm6_sx), .pc_write(pc_write), .branch(branch), .jal(jal), .zero(zero),
    .cur_pc(cur_pc), .link_pc(link_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [15:0] data, input logic [15:0] exp_addr);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, exp_addr);
    imem_ack = 1'b1;
    imem_rdata = data;
    step();
    imem_ack = 1'b0;
    chk("fetch_valid", ir_valid, 1);
    chk("fetch_req_drop", imem_req, 0);
  endtask

  task automatic pcw(input logic b, input logic j, input logic z);
    pc_write = 1'b1; branch = b; jal = j; zero = z;
    step();
    pc_write = 1'b0; branch = 1'b0; jal = 1'b0; zero = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_pc", cur_pc, 16'h0000);
    chk("rst_opcode", opcode, 0);
    chk("rst_fault", fetch_fault, 0);
    reset = 1'b1;

    // zero-wait fetch
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 16'h0000);
    chk("t1_valid_lo", ir_valid, 0);
    imem_ack = 1'b1; imem_rdata = 16'h0A45;
    step();
    imem_ack = 1'b0;
    chk("t1_valid", ir_valid, 1);
    chk("t1_opcode", opcode, 4'h0);
    chk("t1_ra", ra, 5);
    chk("t1_rb", rb, 1);
    chk("t1_rc", rc, 0);
    chk("t1_funct", funct, 1);
    chk("t1_link", link_pc, 16'h0001);

    imem_ack = 1'b1; imem_rdata = 16'hFFFF;
    step();
    imem_ack = 1'b0;
    chk("idle_ack_opcode", opcode, 4'h0);
    chk("idle_ack_req", imem_req, 0);

    // delayed ack with a stray fetch_start mid-wait
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_hold", imem_req, 1);
      chk("t2_addr_hold", imem_addr, 16'h0000);
      chk("t2_valid_lo", ir_valid, 0);
      fetch_start = (i == 2);
      step();
      fetch_start = 1'b0;
    end
    imem_ack = 1'b1; imem_rdata = 16'h2A4B;
    step();
    imem_ack = 1'b0;
    chk("t2_valid", ir_valid, 1);
    chk("t2_opcode", opcode, 4'h2);
    chk("t2_funct", funct, 3);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t2_no_refetch", imem_req, 0);
    end

    // BEQ taken / not taken
    fetch(16'hD010, 16'h0000);
    pcw(1'b0, 1'b1, 1'b0);
    chk("t3_pc_setup", cur_pc, 16'h0010);
    fetch(16'hB03E, 16'h0010);
    chk("t3_opcode", opcode, 4'hB);
    chk("t3_imm6", imm6_sx, 16'hFFFE);
    pcw(1'b1, 1'b0, 1'b1);
    chk("t3_beq_taken", cur_pc, 16'h000E);
    pcw(1'b0, 1'b0, 1'b0);
    chk("t3_inc", cur_pc, 16'h000F);
    pcw(1'b0, 1'b0, 1'b0);
    pcw(1'b1, 1'b0, 1'b0);
    chk("t3_beq_not_taken", cur_pc, 16'h0011);

    // JAL and PC wrap
    fetch(16'hD00F, 16'h0011);
    pcw(1'b0, 1'b1, 1'b0);
    chk("t4_pc_setup", cur_pc, 16'h0020);
    fetch(16'hD605, 16'h0020);
    chk("t4_ra", ra, 3);
    chk("t4_link", link_pc, 16'h0021);
    pcw(1'b0, 1'b1, 1'b0);
    chk("t4_jal", cur_pc, 16'h0025);
    fetch(16'hD1DA, 16'h0025);
    chk("t4_imm6_pos", imm6_sx, 16'h001A);
    pcw(1'b0, 1'b1, 1'b0);
    chk("t4_jal_neg", cur_pc, 16'hFFFF);
    chk("t4_link_wrap", link_pc, 16'h0000);
    pcw(1'b0, 1'b0, 1'b0);
    chk("t4_wrap", cur_pc, 16'h0000);
    pcw(1'b1, 1'b1, 1'b1);
    chk("t4_jal_priority", cur_pc, 16'hFFDA);

    // pc_write together with fetch_start, then reset mid-REQ
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t5_rst_pc", cur_pc, 16'h0000);
    for (int i = 0; i < 4; i++) pcw(1'b0, 1'b0, 1'b0);
    chk("t5_pc4", cur_pc, 16'h0004);
    pc_write = 1'b1; fetch_start = 1'b1;
    step();
    pc_write = 1'b0; fetch_start = 1'b0;
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 16'h0005);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_req", imem_req, 0);
    chk("t5_async_pc", cur_pc, 16'h0000);
    step();
    reset = 1'b1;
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    step();
    imem_ack = 1'b0;
    chk("t5_late_ack_valid", ir_valid, 0);
    chk("t5_late_ack_opcode", opcode, 4'h0);

    // ack never arrives
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    repeat (254) step();
    chk("t6_req_before_to", imem_req, 1);
    step();
    chk("t6_req_to", imem_req, 0);
    chk("t6_fault", fetch_fault, 1);
    chk("t6_opcode", opcode, 4'hF);
`else
    repeat (299) step();
    chk("t6_req_hold", imem_req, 1);
    chk("t6_no_fault", fetch_fault, 0);
    imem_ack = 1'b1; imem_rdata = 16'h9000;
    step();
    imem_ack = 1'b0;
    chk("t6_late_capture", opcode, 4'h9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
